control_unit: RTL and testbench

Hardwired Moore control sequencer that drives the datapath's register-transfer control inputs (PCout, MARin, Zin, Gra/Grb/Grc, Rin/Rout, BAout, opcode, ...) for a Mini-SRC instruction subset. It sits directly upstream of `datapath`. It replaces hand-sequenced T-state stimulus with fetch and execute cycles generated from the IR contents.

---
 rtl/control_unit_if.sv | 38 +++
 rtl/control_unit.sv | 162 ++++++++++++++++
 tb/tb_control_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// control_unit_if: control bus between the Mini-SRC control sequencer and the datapath.
// master = sequencer side (drives strobes), slave = datapath side (drives ir/Stop).
// Optional macro CU_SINGLE_STEP_EN adds the Step request line.
interface control_unit_if;
   logic [31:0] ir;
   logic        Stop;
`ifdef CU_SINGLE_STEP_EN
   logic        Step;
`endif
   logic        Run;
   logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout;
   logic        IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
   logic [4:0]  opcode;

`ifdef CU_SINGLE_STEP_EN
   modport master (
      input  ir, Stop, Step,
      output Run, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout,
             IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, opcode
   );
   modport slave (
      output ir, Stop, Step,
      input  Run, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout,
             IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, opcode
   );
`else
   modport master (
      input  ir, Stop,
      output Run, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout,
             IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, opcode
   );
   modport slave (
      output ir, Stop,
      input  Run, PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout,
             IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, opcode
   );
`endif
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the Mini-SRC datapath.
// Fetch T0-T2 is common; execute T3-T7 is decoded from ir[31:27].
// Optional macro CU_SINGLE_STEP_EN adds a PAUSE state released by Step.
module control_unit #(
   parameter logic [4:0] ADD_OP = 5'b00011
) (
   input  logic           Clock,
   input  logic           clear,
   control_unit_if.master bus
);

   typedef enum logic [3:0] {
      StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
`ifdef CU_SINGLE_STEP_EN
      , StPause
`endif
   } state_t;

   state_t r_state, w_state_next, w_boundary_next;
   logic [4:0] r_opcode, w_opcode;
   logic [4:0] w_op;
   logic w_ld, w_ldi, w_st, w_addi, w_alu, w_halt, w_imm, w_mem, w_exec;

   logic w_run, w_pcout, w_marin, w_incpc, w_zin, w_zlowout, w_pcin, w_read, w_write;
   logic w_mdrin, w_mdrout, w_irin, w_yin, w_gra, w_grb, w_grc, w_rin, w_rout;
   logic w_baout, w_cout;

   assign w_op   = bus.ir[31:27];
   assign w_ld   = (w_op == 5'b00000);
   assign w_ldi  = (w_op == 5'b00001);
   assign w_st   = (w_op == 5'b00010);
   assign w_addi = (w_op == 5'b01011);
   assign w_halt = (w_op == 5'b11011);
   assign w_alu  = (w_op == 5'b00011) || (w_op == 5'b00100) ||
                   (w_op == 5'b01001) || (w_op == 5'b01010);
   assign w_imm  = w_ldi || w_addi;
   assign w_mem  = w_ld || w_st;
   assign w_exec = w_imm || w_mem || w_alu;

   // State and held ALU opcode; clear zeroes both without waiting for Clock.
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         r_state  <= StRst;
         r_opcode <= 5'b00000;
      end else begin
         r_state  <= w_state_next;
         r_opcode <= w_opcode;
      end
   end

   // Next state; w_boundary_next is where an instruction goes after its last state.
   always_comb begin
      w_boundary_next = StT0;
`ifdef CU_SINGLE_STEP_EN
      w_boundary_next = StPause;
`endif
      if (bus.Stop) w_boundary_next = StHalt;

      w_state_next = r_state;
      unique case (r_state)
         StRst:   w_state_next = StT0;
         StT0:    w_state_next = StT1;
         StT1:    w_state_next = StT2;
         // nop and undefined ops end here; their boundary is the end of T2
         StT2:    w_state_next = w_exec ? StT3 : (w_halt ? StHalt : w_boundary_next);
         StT3:    w_state_next = StT4;
         StT4:    w_state_next = StT5;
         StT5:    w_state_next = w_mem ? StT6 : w_boundary_next;
         StT6:    w_state_next = StT7;
         StT7:    w_state_next = w_boundary_next;
         StHalt:  w_state_next = StHalt;
`ifdef CU_SINGLE_STEP_EN
         StPause: w_state_next = bus.Stop ? StHalt : (bus.Step ? StT0 : StPause);
`endif
         default: w_state_next = StRst;
      endcase
   end

   // Moore outputs decoded from state and ir[31:27]; opcode holds unless set in T4.
   always_comb begin
      w_run = 1'b1;
      {w_pcout, w_marin, w_incpc, w_zin, w_zlowout, w_pcin, w_read, w_write} = '0;
      {w_mdrin, w_mdrout, w_irin, w_yin, w_gra, w_grb, w_grc, w_rin, w_rout} = '0;
      {w_baout, w_cout} = '0;
      w_opcode = r_opcode;
      unique case (r_state)
         StT0: {w_pcout, w_marin, w_incpc, w_zin} = 4'b1111;
         StT1: {w_zlowout, w_pcin, w_read, w_mdrin} = 4'b1111;
         StT2: {w_mdrout, w_irin} = 2'b11;
         StT3: begin
            w_grb  = 1'b1;
            w_yin  = 1'b1;
            w_rout = w_alu || w_addi;
            w_baout = !(w_alu || w_addi);
         end
         StT4: begin
            w_zin = 1'b1;
            if (w_alu) begin
               w_grc    = 1'b1;
               w_rout   = 1'b1;
               w_opcode = w_op;
            end else begin
               w_cout   = 1'b1;
               w_opcode = ADD_OP;
            end
         end
         StT5: begin
            w_zlowout = 1'b1;
            if (w_mem) begin
               w_marin = 1'b1;
            end else begin
               w_gra = 1'b1;
               w_rin = 1'b1;
            end
         end
         StT6: begin
            w_mdrin = 1'b1;
            if (w_st) begin
               w_gra  = 1'b1;
               w_rout = 1'b1;
            end else begin
               w_read = 1'b1;
            end
         end
         StT7: begin
            if (w_st) begin
               w_write = 1'b1;
            end else begin
               w_mdrout = 1'b1;
               w_gra    = 1'b1;
               w_rin    = 1'b1;
            end
         end
         StRst:  w_run = 1'b0;
         StHalt: w_run = 1'b0;
         default: w_run = 1'b1;
      endcase
   end

   assign bus.Run     = w_run;
   assign bus.PCout   = w_pcout;
   assign bus.MARin   = w_marin;
   assign bus.IncPC   = w_incpc;
   assign bus.Zin     = w_zin;
   assign bus.Zlowout = w_zlowout;
   assign bus.PCin    = w_pcin;
   assign bus.Read    = w_read;
   assign bus.Write   = w_write;
   assign bus.MDRin   = w_mdrin;
   assign bus.MDRout  = w_mdrout;
   assign bus.IRin    = w_irin;
   assign bus.Yin     = w_yin;
   assign bus.Gra     = w_gra;
   assign bus.Grb     = w_grb;
   assign bus.Grc     = w_grc;
   assign bus.Rin     = w_rin;
   assign bus.Rout    = w_rout;
   assign bus.BAout   = w_baout;
   assign bus.Cout    = w_cout;
   assign bus.opcode  = w_opcode;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the control_unit fetch/execute sequences.
module tb_control_unit;

   logic Clock;
   logic clear;
   int   n_assert;
   int   n_fail;

   control_unit_if bus ();

   control_unit #(.ADD_OP(5'b00011)) dut (
      .Clock (Clock),
      .clear (clear),
      .bus   (bus.master)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   localparam logic [18:0] PCOUT = 19'd1 << 18, MARIN = 19'd1 << 17, INCPC = 19'd1 << 16;
   localparam logic [18:0] ZIN   = 19'd1 << 15, ZLOW  = 19'd1 << 14, PCIN  = 19'd1 << 13;
   localparam logic [18:0] READ  = 19'd1 << 12, WRITE = 19'd1 << 11, MDRIN = 19'd1 << 10;
   localparam logic [18:0] MDROUT = 19'd1 << 9, IRIN  = 19'd1 << 8,  YIN   = 19'd1 << 7;
   localparam logic [18:0] GRA   = 19'd1 << 6,  GRB   = 19'd1 << 5,  GRC   = 19'd1 << 4;
   localparam logic [18:0] RIN   = 19'd1 << 3,  ROUT  = 19'd1 << 2,  BAOUT = 19'd1 << 1;
   localparam logic [18:0] COUT  = 19'd1;
   localparam logic [18:0] F0 = PCOUT | MARIN | INCPC | ZIN;
   localparam logic [18:0] F1 = ZLOW | PCIN | READ | MDRIN;
   localparam logic [18:0] F2 = MDROUT | IRIN;
   localparam logic [18:0] NONE = 19'd0;

   function automatic logic [18:0] strobes();
      return {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.PCin, bus.Read,
              bus.Write, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Gra, bus.Grb,
              bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Cout};
   endfunction

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [18:0] es, input logic [4:0] eop,
                        input logic erun);
      logic [18:0] s;
      logic [2:0]  sel;
      s = strobes();
      sel = {bus.Gra, bus.Grb, bus.Grc};
      n_assert++;
      assert (s === es) else begin
         n_fail++;
         $error("FAIL %s strobes observed=%b expected=%b", tag, s, es);
      end
      n_assert++;
      assert (bus.opcode === eop) else begin
         n_fail++;
         $error("FAIL %s opcode observed=%b expected=%b", tag, bus.opcode, eop);
      end
      n_assert++;
      assert (bus.Run === erun) else begin
         n_fail++;
         $error("FAIL %s Run observed=%b expected=%b", tag, bus.Run, erun);
      end
      n_assert++;
      assert ($countones(sel) <= 1 && !(bus.Read && bus.Write)) else begin
         n_fail++;
         $error("FAIL %s exclusivity observed sel=%b rd=%b wr=%b expected onehot0/no rd+wr",
                tag, sel, bus.Read, bus.Write);
      end
   endtask

   task automatic cyc(input string tag, input logic [18:0] es, input logic [4:0] eop,
                      input logic erun);
      step();
      check(tag, es, eop, erun);
   endtask

   task automatic fetch(input string tag, input logic [4:0] eop);
      cyc({tag, "_t1"}, F1, eop, 1'b1);
      cyc({tag, "_t2"}, F2, eop, 1'b1);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      clear    = 1'b0;
      bus.ir   = 32'h0;
      bus.Stop = 1'b0;

      // Reset, release, then async clear in the middle of T1
      step();
      check("rst", NONE, 5'd0, 1'b0);
      clear = 1'b1;
      cyc("rel_t0", F0, 5'd0, 1'b1);
      cyc("pre_t1", F1, 5'd0, 1'b1);
      #2 clear = 1'b0;
      #1 check("async_clr", NONE, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) cyc("clr_hold", NONE, 5'd0, 1'b0);
      clear = 1'b1;
      cyc("rel2_t0", F0, 5'd0, 1'b1);

      // ldi R2,0x5F(R0)
      bus.ir = 32'h0900005F;
      fetch("ldi", 5'd0);
      cyc("ldi_t3", GRB | BAOUT | YIN, 5'd0, 1'b1);
      cyc("ldi_t4", COUT | ZIN, 5'b00011, 1'b1);
      cyc("ldi_t5", ZLOW | GRA | RIN, 5'b00011, 1'b1);
      cyc("ldi_t0", F0, 5'b00011, 1'b1);

      // add R1,R2,R3
      bus.ir = 32'h18918000;
      fetch("add", 5'b00011);
      cyc("add_t3", GRB | ROUT | YIN, 5'b00011, 1'b1);
      cyc("add_t4", GRC | ROUT | ZIN, 5'b00011, 1'b1);
      cyc("add_t5", ZLOW | GRA | RIN, 5'b00011, 1'b1);
      cyc("add_t0", F0, 5'b00011, 1'b1);

      // sub: opcode follows ir and then holds
      bus.ir = 32'h20918000;
      fetch("sub", 5'b00011);
      cyc("sub_t3", GRB | ROUT | YIN, 5'b00011, 1'b1);
      cyc("sub_t4", GRC | ROUT | ZIN, 5'b00100, 1'b1);
      cyc("sub_t5", ZLOW | GRA | RIN, 5'b00100, 1'b1);
      cyc("sub_t0", F0, 5'b00100, 1'b1);

      // ld
      bus.ir = 32'h00800010;
      fetch("ld", 5'b00100);
      cyc("ld_t3", GRB | BAOUT | YIN, 5'b00100, 1'b1);
      cyc("ld_t4", COUT | ZIN, 5'b00011, 1'b1);
      cyc("ld_t5", ZLOW | MARIN, 5'b00011, 1'b1);
      cyc("ld_t6", READ | MDRIN, 5'b00011, 1'b1);
      cyc("ld_t7", MDROUT | GRA | RIN, 5'b00011, 1'b1);
      cyc("ld_t0", F0, 5'b00011, 1'b1);

      // st
      bus.ir = 32'h10800010;
      fetch("st", 5'b00011);
      cyc("st_t3", GRB | BAOUT | YIN, 5'b00011, 1'b1);
      cyc("st_t4", COUT | ZIN, 5'b00011, 1'b1);
      cyc("st_t5", ZLOW | MARIN, 5'b00011, 1'b1);
      cyc("st_t6", GRA | ROUT | MDRIN, 5'b00011, 1'b1);
      cyc("st_t7", WRITE, 5'b00011, 1'b1);
      cyc("st_t0", F0, 5'b00011, 1'b1);

      // addi with a Stop pulse that does not span the boundary edge
      bus.ir = 32'h58000005;
      fetch("addi", 5'b00011);
      cyc("addi_t3", GRB | ROUT | YIN, 5'b00011, 1'b1);
      bus.Stop = 1'b1;
      cyc("addi_t4", COUT | ZIN, 5'b00011, 1'b1);
      bus.Stop = 1'b0;
      cyc("addi_t5", ZLOW | GRA | RIN, 5'b00011, 1'b1);
      cyc("addi_t0", F0, 5'b00011, 1'b1);

      // nop loops straight back to T0; undefined op behaves the same
      bus.ir = 32'hD0000000;
      fetch("nop1", 5'b00011);
      cyc("nop1_t0", F0, 5'b00011, 1'b1);
      fetch("nop2", 5'b00011);
      cyc("nop2_t0", F0, 5'b00011, 1'b1);
      bus.ir = 32'hF8000000;
      fetch("undef", 5'b00011);
      cyc("undef_t0", F0, 5'b00011, 1'b1);

      // Stop held across the add boundary -> HALT after T5
      bus.ir = 32'h18918000;
      fetch("stop", 5'b00011);
      cyc("stop_t3", GRB | ROUT | YIN, 5'b00011, 1'b1);
      bus.Stop = 1'b1;
      cyc("stop_t4", GRC | ROUT | ZIN, 5'b00011, 1'b1);
      cyc("stop_t5", ZLOW | GRA | RIN, 5'b00011, 1'b1);
      cyc("stop_halt", NONE, 5'b00011, 1'b0);
      bus.Stop = 1'b0;
      cyc("stop_halt2", NONE, 5'b00011, 1'b0);

      // Only clear leaves HALT; then the halt instruction itself
      clear = 1'b0;
      #1 check("halt_clr", NONE, 5'd0, 1'b0);
      step();
      clear = 1'b1;
      cyc("rel3_t0", F0, 5'd0, 1'b1);
      bus.ir = 32'hD8000000;
      fetch("halt", 5'd0);
      for (int i = 0; i < 12; i++) cyc("halt_hold", NONE, 5'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
